// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing block: select codes, flag bit positions, datapath width.
package alu_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_ADC = 4'b0001,
    ALU_SUB = 4'b0010,
    ALU_SBC = 4'b0011,
    ALU_AND = 4'b0100,
    ALU_OR  = 4'b0101,
    ALU_XOR = 4'b0110,
    ALU_NOT = 4'b0111,
    ALU_SHL = 4'b1000,
    ALU_SHR = 4'b1001,
    ALU_ROL = 4'b1010,
    ALU_ROR = 4'b1011,
    ALU_CMP = 4'b1100,
    ALU_INC = 4'b1101,
    ALU_DEC = 4'b1110
  } alu_sel_e;

  // Bit positions inside a {V,N,Z,C} flag nibble
  localparam int FLG_C = 0;
  localparam int FLG_Z = 1;
  localparam int FLG_N = 2;
  localparam int FLG_V = 3;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first eligible index at or after rr_ptr, wrapping modulo NREQ.
module rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  elig,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  // Scan from the farthest offset down so the nearest eligible index wins last.
  always_comb begin
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      int cand;
      cand = (int'(rr_ptr) + k) % NREQ;
      if (elig[cand]) begin
        grant       = '0;
        grant[cand] = 1'b1;
        idx         = IDX_W'(cand);
        valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Round-robin sharing of one combinational 16-bit ALU: issue stage registers operands, capture stage
// returns result/flags to the winner and keeps a private {V,N,Z,C} register per requester.
module alu_share_ctrl #(
  parameter int NREQ   = 4,
  parameter int DATA_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [4*NREQ-1:0]    req_sel,
  input  logic [DATA_W*NREQ-1:0] req_a,
  input  logic [DATA_W*NREQ-1:0] req_b,
  output logic [NREQ-1:0]      ack,
  output logic [NREQ-1:0]      resp_valid,
  output logic [DATA_W-1:0]    resp_data,
  output logic [3:0]           resp_flags,
  output logic [4*NREQ-1:0]    flags_out,
  output logic [DATA_W-1:0]    alu_a,
  output logic [DATA_W-1:0]    alu_b,
  output logic [3:0]           alu_sel,
  output logic                 alu_cin,
  input  logic [DATA_W-1:0]    alu_result,
  input  logic                 alu_c,
  input  logic                 alu_n,
  input  logic                 alu_v,
  input  logic                 alu_z
);

  import alu_pkg::*;

  localparam int IDX_W = $clog2(NREQ);

  logic [3:0]        sel_arr  [NREQ];
  logic [DATA_W-1:0] a_arr    [NREQ];
  logic [DATA_W-1:0] b_arr    [NREQ];
  logic [3:0]        flag_reg [NREQ];

  logic [NREQ-1:0]  pending_reg, pending_next;
  logic [NREQ-1:0]  elig, grant;
  logic [IDX_W-1:0] rr_ptr_reg, rr_ptr_next;
  logic [IDX_W-1:0] win_idx, s1_id_reg;
  logic             win_valid, issue, s1_valid_reg;
  logic [3:0]       cap_flags;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      assign sel_arr[gi] = req_sel[4*gi +: 4];
      assign a_arr[gi]   = req_a[DATA_W*gi +: DATA_W];
      assign b_arr[gi]   = req_b[DATA_W*gi +: DATA_W];
      assign flags_out[4*gi +: 4] = flag_reg[gi];

      always_ff @(posedge clk) begin
        if (reset) begin
          flag_reg[gi] <= '0;
        end else if (s1_valid_reg && (s1_id_reg == IDX_W'(gi))) begin
          flag_reg[gi] <= cap_flags;
        end
      end
    end
  endgenerate

  // A requester with an op in flight is masked, which also guarantees its carry is current at re-issue.
  assign elig = req & ~pending_reg;

  rr_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) u_arb (
    .elig   (elig),
    .rr_ptr (rr_ptr_reg),
    .grant  (grant),
    .idx    (win_idx),
    .valid  (win_valid)
  );

  assign issue = win_valid & ~reset;
  assign ack   = issue ? grant : '0;

  always_comb begin
    cap_flags        = '0;
    cap_flags[FLG_C] = alu_c;
    cap_flags[FLG_Z] = alu_z;
    cap_flags[FLG_N] = alu_n;
    cap_flags[FLG_V] = alu_v;
  end

  always_comb begin
    pending_next = pending_reg;
    if (s1_valid_reg) pending_next[s1_id_reg] = 1'b0;
    if (issue)        pending_next[win_idx]   = 1'b1;
  end

  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (issue) rr_ptr_next = (win_idx == IDX_W'(NREQ - 1)) ? '0 : win_idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      alu_a        <= '0;
      alu_b        <= '0;
      alu_sel      <= '0;
      alu_cin      <= 1'b0;
      s1_valid_reg <= 1'b0;
      s1_id_reg    <= '0;
      pending_reg  <= '0;
      rr_ptr_reg   <= '0;
      resp_valid   <= '0;
      resp_data    <= '0;
      resp_flags   <= '0;
    end else begin
      if (issue) begin
        alu_a     <= a_arr[win_idx];
        alu_b     <= b_arr[win_idx];
        alu_sel   <= sel_arr[win_idx];
        alu_cin   <= flag_reg[win_idx][FLG_C];
        s1_id_reg <= win_idx;
      end
      s1_valid_reg <= issue;
      pending_reg  <= pending_next;
      rr_ptr_reg   <= rr_ptr_next;
      if (s1_valid_reg) begin
        resp_data  <= alu_result;
        resp_flags <= cap_flags;
        resp_valid <= NREQ'(1) << s1_id_reg;
      end else begin
        resp_valid <= '0;
      end
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl with a small behavioural ALU closing the alu_* loop.
module tb_alu_share_ctrl;
  import alu_pkg::*;

  localparam int NREQ = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [15:0] req_sel;
  logic [63:0] req_a, req_b;
  logic [3:0]  ack, resp_valid;
  logic [15:0] resp_data;
  logic [3:0]  resp_flags;
  logic [15:0] flags_out;
  logic [15:0] alu_a, alu_b, alu_result;
  logic [3:0]  alu_sel;
  logic        alu_cin, alu_c, alu_n, alu_v, alu_z;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_share_ctrl #(.NREQ(NREQ), .DATA_W(16)) dut (
    .clk(clk), .reset(reset), .req(req), .req_sel(req_sel), .req_a(req_a), .req_b(req_b),
    .ack(ack), .resp_valid(resp_valid), .resp_data(resp_data), .resp_flags(resp_flags),
    .flags_out(flags_out), .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_cin(alu_cin),
    .alu_result(alu_result), .alu_c(alu_c), .alu_n(alu_n), .alu_v(alu_v), .alu_z(alu_z)
  );

  // Reference ALU: only the selects exercised below need real behaviour.
  logic [16:0] sum;
  always_comb begin
    sum   = {1'b0, alu_a};
    alu_v = 1'b0;
    case (alu_sel)
      ALU_ADD: begin
        sum   = {1'b0, alu_a} + {1'b0, alu_b};
        alu_v = (alu_a[15] == alu_b[15]) && (sum[15] != alu_a[15]);
      end
      ALU_ADC: begin
        sum   = {1'b0, alu_a} + {1'b0, alu_b} + {16'd0, alu_cin};
        alu_v = (alu_a[15] == alu_b[15]) && (sum[15] != alu_a[15]);
      end
      ALU_SUB, ALU_CMP: begin
        sum   = {1'b0, alu_a} + {1'b0, ~alu_b} + 17'd1;
        alu_v = (alu_a[15] != alu_b[15]) && (sum[15] != alu_a[15]);
      end
      ALU_SBC: begin
        sum   = {1'b0, alu_a} + {1'b0, ~alu_b} + {16'd0, alu_cin};
        alu_v = (alu_a[15] != alu_b[15]) && (sum[15] != alu_a[15]);
      end
      ALU_AND: sum = {1'b0, alu_a & alu_b};
      default: sum = {1'b0, alu_a};
    endcase
    alu_result = sum[15:0];
    alu_c      = sum[16];
    alu_n      = sum[15];
    alu_z      = (sum[15:0] == 16'd0);
  end

  typedef struct {
    int          id;
    logic [3:0]  sel;
    logic [15:0] a;
    logic [15:0] b;
    logic        exp_cin;
    logic [15:0] exp_data;
    logic [3:0]  exp_flags;
  } vec_t;

  vec_t vecs [9];
  logic [3:0] exp_flag_arr [4];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic set_op(input int id, input logic [3:0] sel, input logic [15:0] a, input logic [15:0] b);
    req_sel[4*id +: 4]  = sel;
    req_a[16*id +: 16]  = a;
    req_b[16*id +: 16]  = b;
  endtask

  initial begin
    vecs[0] = '{0, ALU_ADD, 16'h0005, 16'h0003, 1'b0, 16'h0008, 4'b0000};
    vecs[1] = '{1, ALU_ADD, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 4'b0011};
    vecs[2] = '{2, ALU_ADC, 16'h0000, 16'h0000, 1'b0, 16'h0000, 4'b0010};
    vecs[3] = '{1, ALU_ADC, 16'h0000, 16'h0000, 1'b1, 16'h0001, 4'b0000};
    vecs[4] = '{3, ALU_SUB, 16'h0003, 16'h0005, 1'b0, 16'hFFFE, 4'b0100};
    vecs[5] = '{0, ALU_AND, 16'hF0F0, 16'h0FF0, 1'b0, 16'h00F0, 4'b0000};
    vecs[6] = '{3, ALU_ADD, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 4'b1100};
    vecs[7] = '{3, ALU_SBC, 16'h0005, 16'h0003, 1'b0, 16'h0001, 4'b0001};
    vecs[8] = '{0, ALU_CMP, 16'h0005, 16'h0005, 1'b0, 16'h0000, 4'b0011};
    for (int i = 0; i < 4; i++) exp_flag_arr[i] = 4'b0000;

    reset = 1'b1; req = 4'b1111; req_sel = '0; req_a = '0; req_b = '0;
    tick; tick;
    chk("reset_ack", 32'(ack), 32'h0);
    chk("reset_resp_valid", 32'(resp_valid), 32'h0);
    chk("reset_resp_data", 32'(resp_data), 32'h0);
    chk("reset_flags_out", 32'(flags_out), 32'h0);
    chk("reset_alu_regs", {alu_a, 11'd0, alu_sel, alu_cin}, 32'h0);
    $display("reset: ack=%b resp_valid=%b flags_out=%h", ack, resp_valid, flags_out);
    reset = 1'b0; req = '0;
    tick;

    // Single-requester ops: ack in T, ALU regs in T+1, response in T+2.
    for (int i = 0; i < 9; i++) begin
      set_op(vecs[i].id, vecs[i].sel, vecs[i].a, vecs[i].b);
      req = 4'(1 << vecs[i].id);
      #1;
      chk($sformatf("v%0d_ack", i), 32'(ack), 32'(1 << vecs[i].id));
      tick;
      req = '0;
      chk($sformatf("v%0d_alu_sel", i), 32'(alu_sel), 32'(vecs[i].sel));
      chk($sformatf("v%0d_alu_ab", i), {alu_a, alu_b}, {vecs[i].a, vecs[i].b});
      chk($sformatf("v%0d_alu_cin", i), 32'(alu_cin), 32'(vecs[i].exp_cin));
      chk($sformatf("v%0d_resp_early", i), 32'(resp_valid), 32'h0);
      tick;
      chk($sformatf("v%0d_resp_valid", i), 32'(resp_valid), 32'(1 << vecs[i].id));
      chk($sformatf("v%0d_resp_data", i), 32'(resp_data), 32'(vecs[i].exp_data));
      chk($sformatf("v%0d_resp_flags", i), 32'(resp_flags), 32'(vecs[i].exp_flags));
      exp_flag_arr[vecs[i].id] = vecs[i].exp_flags;
      $display("vec %0d: id=%0d sel=%b a=%h b=%h -> cin=%b data=%h flags=%b", i, vecs[i].id,
               vecs[i].sel, vecs[i].a, vecs[i].b, alu_cin, resp_data, resp_flags);
    end
    chk("flags_out_table", 32'(flags_out),
        32'({exp_flag_arr[3], exp_flag_arr[2], exp_flag_arr[1], exp_flag_arr[0]}));

    // Reset lands on the capture edge of an in-flight op.
    set_op(0, ALU_ADD, 16'h0001, 16'h0001);
    req = 4'b0001;
    #1;
    chk("rst_inflight_ack", 32'(ack), 32'h1);
    tick;
    reset = 1'b1; req = '0;
    tick;
    reset = 1'b0;
    chk("rst_inflight_resp", 32'(resp_valid), 32'h0);
    chk("rst_inflight_flags", 32'(flags_out), 32'h0);
    tick;
    chk("rst_inflight_resp2", 32'(resp_valid), 32'h0);
    set_op(1, ALU_ADD, 16'h0002, 16'h0002);
    req = 4'b0011;
    #1;
    chk("post_rst_ack0", 32'(ack), 32'h1);
    $display("post-reset: ack=%b", ack);
    tick;
    chk("post_rst_ack1", 32'(ack), 32'h2);
    $display("post-reset: ack=%b", ack);
    tick;
    req = '0;
    tick; tick;

    // All four held: rr_ptr starts at 2 after the 0,1 grants above.
    for (int i = 0; i < 4; i++) set_op(i, ALU_ADD, 16'(i + 1), 16'h0100);
    req = 4'b1111;
    for (int c = 0; c < 10; c++) begin
      if (c == 8) req = '0;
      #1;
      if (c < 8) chk($sformatf("rr_ack_c%0d", c), 32'(ack), 32'(1 << ((2 + c) % 4)));
      else chk($sformatf("rr_ack_c%0d", c), 32'(ack), 32'h0);
      if (c >= 2) begin
        chk($sformatf("rr_resp_c%0d", c), 32'(resp_valid), 32'(1 << (c % 4)));
        chk($sformatf("rr_data_c%0d", c), 32'(resp_data), 32'(16'h0100 + 16'((c % 4) + 1)));
      end
      $display("rr cycle %0d: ack=%b resp_valid=%b data=%h", c, ack, resp_valid, resp_data);
      tick;
    end
    tick;

    // rr_ptr back at 2 with only req0 and req3: 3 first, then 0, leaving the pointer at 1.
    req = 4'b1001;
    #1;
    chk("skip_ack3", 32'(ack), 32'h8);
    $display("skip: ack=%b", ack);
    tick;
    chk("skip_ack0", 32'(ack), 32'h1);
    $display("skip: ack=%b", ack);
    tick;
    req = '0;
    tick; tick;
    req = 4'b1111;
    #1;
    chk("ptr_at_1", 32'(ack), 32'h2);
    $display("ptr probe: ack=%b", ack);
    tick;
    req = '0;
    tick; tick; tick;

    // req2 alone: pending blocks every other cycle.
    req = 4'b0100;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("solo_ack_c%0d", c), 32'(ack), (c % 2 == 0) ? 32'h4 : 32'h0);
      $display("solo cycle %0d: ack=%b", c, ack);
      tick;
    end
    req = '0;
    tick; tick;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
